receive_connector: RTL

- Downstream of uart_rx and upstream of the core's IO-register write port. The receive-side counterpart to transmit_connector.
- Reassembles framed UART bytes into 15-bit AGC IO-register writes (channel select plus data).
- Presents each assembled write to the core through a valid/ready handshake.
- Detects framing errors, inter-byte timeouts and overruns.

---
 rtl/receive_connector.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/receive_connector.sv
// Reassembles 4-byte UART packets (header + three 5-bit data bytes) into 15-bit
// IO-register writes and offers them to the core over a valid/ready handshake.
module receive_connector #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_rx_valid,
    input  logic [7:0]  uart_rx_data,
    input  logic        io_wr_ready,
    input  logic        err_clear,
    output logic        io_wr_valid,
    output logic [6:0]  io_wr_sel,
    output logic [14:0] io_wr_data,
    output logic        frame_err,
    output logic        overrun,
    output logic [7:0]  pkt_count
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GOT_H  = 2'd1;
    localparam logic [1:0] S_GOT_D0 = 2'd2;
    localparam logic [1:0] S_GOT_D1 = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [6:0]       chan_q, chan_d;
    logic [9:0]       part_q, part_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [6:0]       sel_q, sel_d;
    logic [14:0]      data_q, data_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic [7:0]       pkt_q, pkt_d;
    logic             out_free;

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        part_d   = part_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        sel_d    = sel_q;
        data_d   = data_q;
        pkt_d    = pkt_q;
        ferr_d   = ferr_q & ~err_clear;
        ovr_d    = ovr_q & ~err_clear;
        // A write being accepted this cycle frees the output for a same-cycle reload.
        out_free = !valid_q || io_wr_ready;

        if (valid_q && io_wr_ready) begin
            valid_d = 1'b0;
        end

        if (uart_rx_valid) begin
            cnt_d = '0;
            if (uart_rx_data[7]) begin
                if (state_q != S_IDLE) begin
                    ferr_d = 1'b1;
                end
                chan_d  = uart_rx_data[6:0];
                state_d = S_GOT_H;
            end else if (state_q == S_IDLE) begin
                ferr_d = 1'b1;
            end else if (uart_rx_data[6:5] != 2'b00) begin
                ferr_d  = 1'b1;
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_GOT_H: begin
                        part_d[9:5] = uart_rx_data[4:0];
                        state_d     = S_GOT_D0;
                    end
                    S_GOT_D0: begin
                        part_d[4:0] = uart_rx_data[4:0];
                        state_d     = S_GOT_D1;
                    end
                    S_GOT_D1: begin
                        state_d = S_IDLE;
                        if (out_free) begin
                            valid_d = 1'b1;
                            sel_d   = chan_q;
                            data_d  = {part_q, uart_rx_data[4:0]};
                            pkt_d   = pkt_q + 8'd1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (state_q != S_IDLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d = S_IDLE;
                ferr_d  = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            chan_q  <= '0;
            part_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
            data_q  <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            pkt_q   <= pkt_d;
        end
    end

    assign io_wr_valid = valid_q;
    assign io_wr_sel   = sel_q;
    assign io_wr_data  = data_q;
    assign frame_err   = ferr_q;
    assign overrun     = ovr_q;
    assign pkt_count   = pkt_q;

endmodule
